// File: rtl/serial_ck_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_ck_rx
// Purpose  : Receive side of a serial clock/data link. Detects leading and
//            trailing edges of sck relative to an idle level, shifts sdat in
//            MSB first on every leading edge, and presents each completed
//            frame of ncyc bits as a right-justified 32-bit word through a
//            one-entry valid/ready holding register. Stalled frames abort
//            after a programmable number of clk cycles without any sck edge.
// Ports    : clk, rst_n (async, active low)
//            y0          - idle level of sck, latched at frame start
//            ncyc[7:0]   - bits per frame (0 behaves as 1), latched at start
//            timeout[31:0] - idle clk cycles before abort, 0 = never
//            sck, sdat   - serial clock / data inputs
//            dout_ready  - consumer accepts dout
//            dout[31:0], dout_valid - received word and its valid flag
//            frame_err   - one-cycle pulse on timeout abort
//            overrun     - one-cycle pulse when a completed word is dropped
//            busy        - frame in progress (SHIFT state)
// Config   : define SERIAL_CK_RX_SYNC_EN to pass sck/sdat through 2-flop
//            synchronizers (asynchronous sources, +2 cycles latency).
// Revision : 1.0 - initial release
// ============================================================================
module serial_ck_rx #(
    parameter logic        P_Y_INIT    = 1'b0,
    parameter logic [31:0] P_DOUT_INIT = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        y0,
    input  logic [7:0]  ncyc,
    input  logic [31:0] timeout,
    input  logic        sck,
    input  logic        sdat,
    input  logic        dout_ready,
    output logic [31:0] dout,
    output logic        dout_valid,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam logic [31:0] C_TIMER_MAX = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input stage
    // ------------------------------------------------------------------
    logic w_sck_q;
    logic w_sdat_q;
    logic r_sck_d;

`ifdef SERIAL_CK_RX_SYNC_EN
    logic [1:0] r_sck_sync;
    logic [1:0] r_sdat_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= {2{P_Y_INIT}};
            r_sdat_sync <= 2'b00;
        end else begin
            r_sck_sync  <= {r_sck_sync[0], sck};
            r_sdat_sync <= {r_sdat_sync[0], sdat};
        end
    end

    assign w_sck_q  = r_sck_sync[1];
    assign w_sdat_q = r_sdat_sync[1];
`else
    // Source is synchronous to clk: use the pins directly.
    assign w_sck_q  = sck;
    assign w_sdat_q = sdat;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_d <= P_Y_INIT;
        end else begin
            r_sck_d <= w_sck_q;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      r_state;
    logic        r_y_lat;
    logic [7:0]  r_n_lat;
    logic [31:0] r_shreg;
    logic [7:0]  r_bit_cnt;
    logic [31:0] r_timer;
    logic [31:0] r_dout;
    logic        r_dout_valid;
    logic        r_frame_err;
    logic        r_overrun;

    state_t      w_state_nxt;
    logic        w_y_lat_nxt;
    logic [7:0]  w_n_lat_nxt;
    logic [31:0] w_shreg_nxt;
    logic [7:0]  w_bit_cnt_nxt;
    logic [31:0] w_timer_nxt;
    logic [31:0] w_dout_nxt;
    logic        w_dout_valid_nxt;
    logic        w_frame_err_nxt;
    logic        w_overrun_nxt;

    logic        w_y_ref;
    logic        w_lead;
    logic        w_trail;
    logic [31:0] w_timer_inc;
    logic [7:0]  w_bit_cnt_inc;
    logic        w_complete;
    logic        w_load;

    // In IDLE the start edge is judged against the live idle level; once a
    // frame is running the latched level is used so y0 changes are ignored.
    assign w_y_ref = (r_state == S_IDLE) ? y0 : r_y_lat;
    assign w_lead  = (w_sck_q == ~w_y_ref) && (r_sck_d == w_y_ref);
    assign w_trail = (w_sck_q == w_y_ref) && (r_sck_d == ~w_y_ref);

    assign w_timer_inc   = (r_timer == C_TIMER_MAX) ? r_timer : r_timer + 32'd1;
    assign w_bit_cnt_inc = r_bit_cnt + 8'd1;

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_y_lat_nxt     = r_y_lat;
        w_n_lat_nxt     = r_n_lat;
        w_shreg_nxt     = r_shreg;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_timer_nxt     = r_timer;
        w_frame_err_nxt = 1'b0;
        w_complete      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_y_lat_nxt = y0;
                if (w_lead) begin
                    w_n_lat_nxt   = (ncyc == 8'd0) ? 8'd1 : ncyc;
                    w_shreg_nxt   = {31'b0, w_sdat_q};
                    w_bit_cnt_nxt = 8'd1;
                    w_timer_nxt   = 32'd0;
                    // Single-bit frames complete on the start edge itself.
                    if (ncyc <= 8'd1) begin
                        w_complete = 1'b1;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                if (w_lead) begin
                    w_shreg_nxt   = {r_shreg[30:0], w_sdat_q};
                    w_bit_cnt_nxt = w_bit_cnt_inc;
                    w_timer_nxt   = 32'd0;
                    if (w_bit_cnt_inc == r_n_lat) begin
                        w_complete  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_trail) begin
                    w_timer_nxt = 32'd0;
                end else begin
                    w_timer_nxt = w_timer_inc;
                    // Abort on the clk edge where the idle count reaches
                    // the programmed limit; the partial word is discarded.
                    if ((timeout != 32'd0) && (w_timer_inc == timeout)) begin
                        w_state_nxt     = S_IDLE;
                        w_frame_err_nxt = 1'b1;
                        w_bit_cnt_nxt   = 8'd0;
                        w_timer_nxt     = 32'd0;
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Holding register: a completion is accepted when the slot is empty or
    // is being emptied in the same cycle; otherwise the new word is lost.
    // ------------------------------------------------------------------
    always_comb begin
        w_load           = w_complete && (!r_dout_valid || dout_ready);
        w_overrun_nxt    = w_complete && !w_load;
        w_dout_nxt       = r_dout;
        w_dout_valid_nxt = r_dout_valid;
        if (w_load) begin
            w_dout_nxt       = w_shreg_nxt;
            w_dout_valid_nxt = 1'b1;
        end else if (r_dout_valid && dout_ready) begin
            w_dout_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_y_lat      <= P_Y_INIT;
            r_n_lat      <= 8'd1;
            r_shreg      <= 32'd0;
            r_bit_cnt    <= 8'd0;
            r_timer      <= 32'd0;
            r_dout       <= P_DOUT_INIT;
            r_dout_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_y_lat      <= w_y_lat_nxt;
            r_n_lat      <= w_n_lat_nxt;
            r_shreg      <= w_shreg_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_timer      <= w_timer_nxt;
            r_dout       <= w_dout_nxt;
            r_dout_valid <= w_dout_valid_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_overrun    <= w_overrun_nxt;
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;
    assign busy       = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_serial_ck_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_ck_rx
// Purpose  : Self-checking bench for serial_ck_rx. Frames are described as
//            bit patterns; expected words are the last min(n,32) bits sent.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_ck_rx;

`ifdef SERIAL_CK_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        y0 = 1'b0;
    logic [7:0]  ncyc = 8'd8;
    logic [31:0] timeout = 32'd0;
    logic        sck = 1'b0;
    logic        sdat = 1'b0;
    logic        dout_ready = 1'b0;
    logic [31:0] dout;
    logic        dout_valid;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Monitor-owned observations
    int cyc = 0;
    int ovr_cnt = 0, fe_cnt = 0, busy_cnt = 0, val_cnt = 0;
    int last_rise_cyc = -1, last_fe_cyc = -1;
    logic prev_valid = 1'b0;
    logic [31:0] acc_q[$];

    // Driver-owned bookkeeping
    int last_lead_cyc = 0;
    int last_edge_cyc = 0;

    serial_ck_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .y0         (y0),
        .ncyc       (ncyc),
        .timeout    (timeout),
        .sck        (sck),
        .sdat       (sdat),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer view: a word is taken whenever valid and ready meet.
    always @(negedge clk) begin
        if (rst_n && dout_valid && dout_ready) acc_q.push_back(dout);
        if (overrun)    ovr_cnt  <= ovr_cnt + 1;
        if (frame_err) begin
            fe_cnt      <= fe_cnt + 1;
            last_fe_cyc <= cyc;
        end
        if (busy)       busy_cnt <= busy_cnt + 1;
        if (dout_valid) val_cnt  <= val_cnt + 1;
        if (dout_valid && !prev_valid) last_rise_cyc <= cyc;
        prev_valid <= dout_valid;
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int bits_of(input logic [7:0] n_field);
        return (n_field == 8'd0) ? 1 : int'(n_field);
    endfunction

    // Reference: the word is simply the last min(n,32) bits of the pattern.
    function automatic logic [31:0] exp_word(input logic [63:0] pat, input int nb);
        logic [31:0] m;
        if (nb >= 32) return pat[31:0];
        m = (32'h1 << nb) - 32'h1;
        return pat[31:0] & m;
    endfunction

    // Sends nsend bits (MSB first of a frame of bits_of(n_field) bits) with
    // half period h. Optionally raises dout_ready exactly for the clk edge
    // that detects the final leading edge.
    task automatic send_frame(input logic y, input logic [7:0] n_field,
                              input logic [63:0] pat, input int h,
                              input int nsend, input bit raise_ready);
        int nb;
        nb   = bits_of(n_field);
        y0   = y;
        ncyc = n_field;
        sck  = y;
        step(4);
        for (int i = 0; i < nsend; i++) begin
            sdat = pat[nb - 1 - i];
            sck  = ~y;
            last_lead_cyc = cyc;
            for (int k = 0; k < h; k++) begin
                if (raise_ready && i == nsend - 1 && k == LAT)     dout_ready = 1'b1;
                if (raise_ready && i == nsend - 1 && k == LAT + 1) dout_ready = 1'b0;
                step(1);
            end
            sck = y;
            last_edge_cyc = cyc;
            step(h);
        end
    endtask

    task automatic test_reset;
        logic [31:0] obs [5];
        logic [31:0] expv[5];
        string       nm  [5];
        rst_n = 1'b0;
        step(3);
        obs[0] = dout;              expv[0] = 32'h0; nm[0] = "reset_dout";
        obs[1] = 32'(dout_valid);   expv[1] = 32'h0; nm[1] = "reset_valid";
        obs[2] = 32'(frame_err);    expv[2] = 32'h0; nm[2] = "reset_frame_err";
        obs[3] = 32'(overrun);      expv[3] = 32'h0; nm[3] = "reset_overrun";
        obs[4] = 32'(busy);         expv[4] = 32'h0; nm[4] = "reset_busy";
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs[i] !== expv[i]) $display("FAIL %s got=%h exp=%h", nm[i], obs[i], expv[i]);
            else n_pass++;
        end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_basic;
        int b0, v0;
        logic [31:0] got;
        acc_q.delete();
        dout_ready = 1'b1;
        timeout    = 32'd0;
        b0 = busy_cnt; v0 = val_cnt;
        send_frame(1'b0, 8'd8, 64'hA5, 2, 8, 1'b0);
        step(LAT + 3);
        n_checks++;
        if (acc_q.size() != 1) $display("FAIL basic_count got=%0d exp=1", acc_q.size());
        else begin
            got = acc_q.pop_front();
            if (got !== 32'h000000A5) $display("FAIL basic_word got=%h exp=000000a5", got);
            else n_pass++;
        end
        n_checks++;
        if (val_cnt - v0 != 1) $display("FAIL basic_valid_cycles got=%0d exp=1", val_cnt - v0);
        else n_pass++;
        n_checks++;
        if (busy_cnt - b0 != 28) $display("FAIL basic_busy_cycles got=%0d exp=28", busy_cnt - b0);
        else n_pass++;
        n_checks++;
        if (last_rise_cyc != last_lead_cyc + 1 + LAT)
            $display("FAIL basic_latency got=%0d exp=%0d", last_rise_cyc, last_lead_cyc + 1 + LAT);
        else n_pass++;
    endtask

    task automatic test_inverted_single;
        int b0;
        logic [31:0] got;
        acc_q.delete();
        dout_ready = 1'b1;
        b0 = busy_cnt;
        send_frame(1'b1, 8'd1, 64'h1, 2, 1, 1'b0);
        step(LAT + 3);
        n_checks++;
        if (acc_q.size() != 1) $display("FAIL inv_count got=%0d exp=1", acc_q.size());
        else begin
            got = acc_q.pop_front();
            if (got !== 32'h1) $display("FAIL inv_word got=%h exp=00000001", got);
            else n_pass++;
        end
        n_checks++;
        if (last_rise_cyc != last_lead_cyc + 1 + LAT)
            $display("FAIL inv_latency got=%0d exp=%0d", last_rise_cyc, last_lead_cyc + 1 + LAT);
        else n_pass++;
        // ncyc = 0 behaves as a single-bit frame
        send_frame(1'b1, 8'd0, 64'h0, 3, 1, 1'b0);
        step(LAT + 3);
        n_checks++;
        if (acc_q.size() != 1) $display("FAIL ncyc0_count got=%0d exp=1", acc_q.size());
        else begin
            got = acc_q.pop_front();
            if (got !== 32'h0) $display("FAIL ncyc0_word got=%h exp=00000000", got);
            else n_pass++;
        end
        n_checks++;
        if (busy_cnt != b0) $display("FAIL inv_busy got=%0d exp=0", busy_cnt - b0);
        else n_pass++;
    endtask

    task automatic test_long40;
        logic [31:0] got;
        acc_q.delete();
        dout_ready = 1'b1;
        send_frame(1'b0, 8'd40, 64'h00FF_1234_5678, 2, 40, 1'b0);
        step(LAT + 3);
        n_checks++;
        if (acc_q.size() != 1) $display("FAIL long40_count got=%0d exp=1", acc_q.size());
        else begin
            got = acc_q.pop_front();
            if (got !== 32'h12345678) $display("FAIL long40_word got=%h exp=12345678", got);
            else n_pass++;
        end
    endtask

    task automatic test_overrun;
        int o0;
        logic [31:0] got;
        for (int pass = 0; pass < 2; pass++) begin
            acc_q.delete();
            dout_ready = 1'b0;
            o0 = ovr_cnt;
            send_frame(1'b0, 8'd8, 64'h11, 4, 8, 1'b0);
            send_frame(1'b0, 8'd8, 64'h22, 4, 8, pass == 1);
            step(LAT + 3);
            n_checks++;
            if (dout_valid !== 1'b1) $display("FAIL ovr%0d_valid got=%b exp=1", pass, dout_valid);
            else n_pass++;
            n_checks++;
            if (dout !== ((pass == 1) ? 32'h22 : 32'h11))
                $display("FAIL ovr%0d_dout got=%h exp=%h", pass, dout, (pass == 1) ? 32'h22 : 32'h11);
            else n_pass++;
            n_checks++;
            if (ovr_cnt - o0 != ((pass == 1) ? 0 : 1))
                $display("FAIL ovr%0d_pulses got=%0d exp=%0d", pass, ovr_cnt - o0, (pass == 1) ? 0 : 1);
            else n_pass++;
            dout_ready = 1'b1;
            step(1);
            dout_ready = 1'b0;
            step(1);
            // pass 0: only 8'h11 ever drained; pass 1: 11 taken on the
            // completion edge, then 22 drained.
            n_checks++;
            if (acc_q.size() != pass + 1) $display("FAIL ovr%0d_accepted got=%0d exp=%0d", pass, acc_q.size(), pass + 1);
            else begin
                got = acc_q.pop_back();
                if (got !== ((pass == 1) ? 32'h22 : 32'h11))
                    $display("FAIL ovr%0d_last_word got=%h exp=%h", pass, got, (pass == 1) ? 32'h22 : 32'h11);
                else n_pass++;
            end
            n_checks++;
            if (dout_valid !== 1'b0) $display("FAIL ovr%0d_drained got=%b exp=0", pass, dout_valid);
            else n_pass++;
        end
    endtask

    task automatic test_timeout;
        int f0;
        logic [31:0] got;
        acc_q.delete();
        dout_ready = 1'b1;
        timeout    = 32'd10;
        f0 = fe_cnt;
        send_frame(1'b0, 8'd8, 64'hB0, 2, 3, 1'b0);
        step(14);
        n_checks++;
        if (fe_cnt - f0 != 1) $display("FAIL timeout_pulses got=%0d exp=1", fe_cnt - f0);
        else n_pass++;
        n_checks++;
        if (last_fe_cyc != last_edge_cyc + 1 + LAT + 10)
            $display("FAIL timeout_timing got=%0d exp=%0d", last_fe_cyc, last_edge_cyc + 11 + LAT);
        else n_pass++;
        n_checks++;
        if (acc_q.size() != 0 || dout_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL timeout_discard got=%0d/%b/%b exp=0/0/0", acc_q.size(), dout_valid, busy);
        else n_pass++;
        send_frame(1'b0, 8'd8, 64'h3C, 2, 8, 1'b0);
        step(LAT + 3);
        n_checks++;
        if (acc_q.size() != 1) $display("FAIL timeout_next_count got=%0d exp=1", acc_q.size());
        else begin
            got = acc_q.pop_front();
            if (got !== 32'h3C) $display("FAIL timeout_next_word got=%h exp=0000003c", got);
            else n_pass++;
        end
        timeout = 32'd0;
    endtask

    task automatic test_reset_midframe;
        int f0;
        logic [31:0] got;
        acc_q.delete();
        dout_ready = 1'b1;
        f0 = fe_cnt;
        send_frame(1'b0, 8'd8, 64'hC3, 2, 4, 1'b0);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL midrst_busy_before got=%b exp=1", busy);
        else n_pass++;
        rst_n = 1'b0;
        step(2);
        n_checks++;
        if (dout !== 32'h0 || dout_valid !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0)
            $display("FAIL midrst_outputs got=%h/%b/%b/%b/%b exp=0/0/0/0/0",
                     dout, dout_valid, busy, frame_err, overrun);
        else n_pass++;
        rst_n = 1'b1;
        step(2);
        send_frame(1'b0, 8'd8, 64'h5A, 2, 8, 1'b0);
        step(LAT + 3);
        n_checks++;
        if (acc_q.size() != 1) $display("FAIL midrst_count got=%0d exp=1", acc_q.size());
        else begin
            got = acc_q.pop_front();
            if (got !== 32'h5A) $display("FAIL midrst_word got=%h exp=0000005a", got);
            else n_pass++;
        end
        n_checks++;
        if (fe_cnt != f0) $display("FAIL midrst_frame_err got=%0d exp=0", fe_cnt - f0);
        else n_pass++;
    endtask

    task automatic test_random;
        int o0, f0, h;
        logic        y;
        logic [7:0]  n;
        logic [63:0] pat;
        logic [31:0] got, expv;
        acc_q.delete();
        dout_ready = 1'b1;
        o0 = ovr_cnt; f0 = fe_cnt;
        for (int it = 0; it < 30; it++) begin
            y       = 1'($urandom_range(0, 1));
            n       = 8'($urandom_range(0, 40));
            pat     = {$urandom(), $urandom()};
            h       = int'($urandom_range(2, 4));
            timeout = ($urandom_range(0, 1) == 1) ? 32'd30 : 32'd0;
            expv    = exp_word(pat, bits_of(n));
            send_frame(y, n, pat, h, bits_of(n), 1'b0);
            step(LAT + 2);
            n_checks++;
            if (acc_q.size() != 1) begin
                $display("FAIL rand%0d_count got=%0d exp=1", it, acc_q.size());
                acc_q.delete();
            end else begin
                got = acc_q.pop_front();
                if (got !== expv) $display("FAIL rand%0d_word n=%0d got=%h exp=%h", it, n, got, expv);
                else n_pass++;
            end
        end
        n_checks++;
        if (ovr_cnt != o0 || fe_cnt != f0)
            $display("FAIL rand_pulses got=%0d/%0d exp=0/0", ovr_cnt - o0, fe_cnt - f0);
        else n_pass++;
        timeout = 32'd0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_inverted_single();
        test_long40();
        test_overrun();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_ck_rx.md
# serial_ck_rx

Receive-side companion to `serial_ck`: samples a serial clock/data pair (clock produced by `serial_ck` or a remote copy of it) and assembles each frame of `ncyc` bits, MSB first, into a 32-bit word. It sits directly downstream of the serial clock transmitter. It hands completed words to the fabric through a one-entry valid/ready holding register, and flags stalled frames (timeout) and dropped words (overrun).

## Interface
- `P_Y_INIT`, 0: reset level of the internal `sck` sample/synchronizer flops.
- `P_DOUT_INIT`, 32'h0: reset value of `dout`.
- `clk` in 1: system clock; all logic on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `y0` in 1: idle level of `sck`; latched at frame start.
- `ncyc` in 8: bits per frame; 0 treated as 1; latched at frame start.
- `timeout` in 32: `clk` cycles without any `sck` edge before a frame aborts; 0 disables.
- `sck` in 1: serial clock input.
- `sdat` in 1: serial data input.
- `dout_ready` in 1: consumer accepts `dout`.
- `dout` out 32: received word, right-justified.
- `dout_valid` out 1: `dout` holds an unconsumed word.
- `frame_err` out 1: one-cycle pulse on timeout abort.
- `overrun` out 1: one-cycle pulse when a completed word is dropped.
- `busy` out 1: high while a frame is in progress.

## Operation
- Input stage: `sck_q`/`sdat_q` are the (optionally synchronized) inputs; `sck_d` is `sck_q` delayed one `clk`.
- Leading edge: `sck_q == !y_lat && sck_d == y_lat`. Trailing edge: the reverse.
- FSM IDLE:
  - `y_lat` tracks `y0`; `busy` = 0.
  - A leading edge (judged against live `y0`) latches `y0`→`y_lat` and `ncyc`→`n_lat` (0→1).
  - On that edge: `shreg` = {31'b0, `sdat_q`}, `bit_cnt` = 1, timer = 0.
  - If `n_lat` == 1, go to COMPLETE action; otherwise go to SHIFT.
- FSM SHIFT:
  - Each leading edge: `shreg` = {`shreg[30:0]`, `sdat_q`}, `bit_cnt`+1, timer cleared.
  - A trailing edge clears the timer only.
  - When the shift makes `bit_cnt == n_lat`, perform the COMPLETE action and return to IDLE.
  - The timer increments, saturating at 2^32−1, on cycles with no edge. If `timeout` != 0 and timer == `timeout`: go to IDLE, pulse `frame_err`, discard the partial word.
- COMPLETE action, same clock edge as the last shift:
  - If `dout_valid` = 0, or `dout_ready` = 1 this cycle: `dout` = new `shreg`, `dout_valid` = 1.
  - Otherwise: pulse `overrun`, keep the old `dout`, drop the new word.
- Handshake:
  - `dout_valid && dout_ready` with no completion clears `dout_valid` next edge.
  - A completion and `dout_ready` in the same cycle loads the new word; `dout_valid` stays 1; no `overrun`.
- Width rule: `ncyc` ≤ 32 leaves upper bits 0. `ncyc` > 32 keeps only the last 32 bits received.
- Changes to `y0`/`ncyc` mid-frame are ignored until the next IDLE.
- `busy` = (state == SHIFT).

## Timing
- Reset values: `dout` = `P_DOUT_INIT`; `dout_valid`, `frame_err`, `overrun`, `busy` = 0; FSM IDLE; timer/`bit_cnt` 0; `sck_q`, `sck_d`, sync flops = `P_Y_INIT`.
- `rst_n` asserted mid-frame aborts immediately with no `frame_err`. The first leading edge after release starts a fresh frame.
- Edge-detect latency: an edge is acted on at the first `clk` edge where `sck_q` shows the new level (0 extra cycles without sync, +2 with).
- `dout_valid` rises on the same `clk` edge as the final shift.
- `sdat` must be stable during the `clk` edge that detects the leading edge (post-sync when enabled).
- Minimum `sck` half period: 1 `clk` without sync, 2 with. `serial_ck` with n1, n2 ≥ 2 satisfies both.

## Configuration
- `SERIAL_CK_RX_SYNC_EN` defined: `sck` and `sdat` each pass a 2-flop synchronizer (reset to `P_Y_INIT`/0), adding 2 cycles of latency. Use this for asynchronous sources.
- Not defined: `sck_q = sck` and `sdat_q = sdat` directly. Valid only when the source is synchronous to `clk` (same-chip `serial_ck`).

## Test plan
- `y0`=0, `ncyc`=8, `timeout`=0, byte 8'hA5 MSB first, `dout_ready`=1 → `dout`=32'h000000A5, one-cycle `dout_valid`, `busy` high from 1st to 8th leading edge.
- `y0`=1 (inverted clock), `ncyc`=1, `sdat`=1 → `dout`=32'h1 on the first falling `sck` edge; `busy` never asserts.
- `ncyc`=40, pattern 40'hFF_1234_5678 → `dout`=32'h12345678.
- `dout_ready`=0, two 8-bit frames 8'h11 then 8'h22 → `dout` stays 8'h11, `overrun` pulses once on the 2nd completion. Repeat with `dout_ready` raised exactly on the 2nd completion cycle → `dout`=8'h22, no `overrun`.
- `ncyc`=8, `timeout`=10, `sck` stops after 3 bits → `frame_err` pulses 10 cycles after the last edge, `dout_valid` stays 0. The next full frame 8'h3C is received correctly.
- Drop `rst_n` after 4 bits of a frame → all outputs return to reset values. A following 8'h5A frame yields `dout`=8'h5A.
